// File: rtl/apb_master_ms.sv
// apb_master_ms: single-outstanding APB master that bridges a valid/ready request port to NSLV completers.
// Optional wait-state abort is compiled in with `define APB_TIMEOUT_EN.
module apb_master_ms #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NSLV    = 4,
  parameter int unsigned SEL_LSB = 28,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  input  logic [DATA_W/8-1:0]    req_strb,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [NSLV-1:0]        PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [ADDR_W-1:0]      PADDR,
  output logic [DATA_W-1:0]      PWDATA,
  output logic [DATA_W/8-1:0]    PSTRB,
  input  logic [NSLV*DATA_W-1:0] PRDATA,
  input  logic [NSLV-1:0]        PREADY,
  input  logic [NSLV-1:0]        PSLVERR
);

  localparam int unsigned SW = (NSLV > 1) ? $clog2(NSLV) : 1;

  // Reject parameter sets the datapath cannot represent.
  if (NSLV < 1 || NSLV > 16 || TIMEOUT < 1 || (SEL_LSB + SW) > ADDR_W ||
      (DATA_W != 8 && DATA_W != 16 && DATA_W != 32)) begin : g_bad_cfg
    $error("apb_master_ms: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SW-1:0]     idx_q;
  logic [SW-1:0]     req_idx;
  logic              req_dec_ok;
  logic [NSLV-1:0]   req_onehot;
  logic              sel_ready;
  logic              sel_err;
  logic [DATA_W-1:0] sel_rdata;
  logic              capture;
  logic [NSLV-1:0]   psel_d;
  logic              penable_d;
  logic              rsp_valid_d;
  logic              rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_d;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_q, wait_d;
`endif

  assign req_idx    = req_addr[SEL_LSB +: SW];
  assign req_dec_ok = (32'(req_idx) < NSLV);

  // Request decode and completer-side mux; unselected completers never reach the datapath.
  always_comb begin
    req_onehot = '0;
    sel_ready  = 1'b0;
    sel_err    = 1'b0;
    sel_rdata  = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (req_idx == SW'(i)) req_onehot[i] = 1'b1;
      if (idx_q == SW'(i)) begin
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
        sel_rdata = PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next state and next values of the registered bus/response outputs.
  always_comb begin
    state_d     = state_q;
    psel_d      = PSEL;
    penable_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    capture     = 1'b0;
`ifdef APB_TIMEOUT_EN
    wait_d      = wait_q;
`endif
    unique case (state_q)
      IDLE: begin
        psel_d = '0;
        if (req_valid) begin
          capture = 1'b1;
          if (req_dec_ok) begin
            state_d = SETUP;
            psel_d  = req_onehot;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
        wait_d    = '0;
`endif
      end
      ACCESS: begin
        if (sel_ready) begin
          state_d     = IDLE;
          psel_d      = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = sel_err;
          rsp_rdata_d = PWRITE ? '0 : sel_rdata;
        end else begin
          penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
          // Abort once the wait-state count reaches the limit; the bus drops next cycle.
          wait_d = wait_q + CNT_W'(1);
          if (32'(wait_d) == TIMEOUT) begin
            state_d     = IDLE;
            psel_d      = '0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        psel_d  = '0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Registered bus, response and captured-request state.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      req_ready <= 1'b1;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      idx_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      req_ready <= (state_d == IDLE);
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      if (capture) begin
        PWRITE <= req_write;
        PADDR  <= req_addr;
        PWDATA <= req_wdata;
        PSTRB  <= req_write ? req_strb : '0;
        idx_q  <= req_idx;
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) wait_q <= '0;
    else          wait_q <= wait_d;
  end
`endif

endmodule

// File: tb/tb_apb_master_ms.sv
// Scoreboard bench for apb_master_ms: randomized requests, reactive completer model, decoupled response monitor.
module tb_apb_master_ms;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NSLV    = 3;
  localparam int unsigned SEL_LSB = 28;
  localparam int unsigned TMO     = 8;

  logic                   PCLK = 1'b0;
  logic                   PRESETn = 1'b0;
  logic                   req_valid = 1'b0;
  logic                   req_ready;
  logic                   req_write = 1'b0;
  logic [ADDR_W-1:0]      req_addr = '0;
  logic [DATA_W-1:0]      req_wdata = '0;
  logic [DATA_W/8-1:0]    req_strb = '0;
  logic                   rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   rsp_err;
  logic [NSLV-1:0]        PSEL;
  logic                   PENABLE;
  logic                   PWRITE;
  logic [ADDR_W-1:0]      PADDR;
  logic [DATA_W-1:0]      PWDATA;
  logic [DATA_W/8-1:0]    PSTRB;
  logic [NSLV*DATA_W-1:0] PRDATA = '0;
  logic [NSLV-1:0]        PREADY = '0;
  logic [NSLV-1:0]        PSLVERR = '0;

  apb_master_ms #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLV(NSLV), .SEL_LSB(SEL_LSB), .TIMEOUT(TMO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          idx;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mh;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          wait_cfg[NSLV];
  logic [31:0] rd_cfg[NSLV];
  logic        er_cfg[NSLV];
  int          acc[NSLV];
  logic        prev_sel = 1'b0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Completer model: selected slave answers after wait_cfg ACCESS cycles; everything else is noise.
  always @(negedge PCLK) begin
    for (int i = 0; i < NSLV; i++) begin
      if (PSEL[i] && PENABLE) begin
        PREADY[i]          = (acc[i] >= wait_cfg[i]);
        PSLVERR[i]         = PREADY[i] ? er_cfg[i] : 1'($urandom);
        PRDATA[i*32 +: 32] = PREADY[i] ? rd_cfg[i] : $urandom;
        acc[i]++;
      end else begin
        acc[i]             = 0;
        PREADY[i]          = 1'($urandom);
        PSLVERR[i]         = 1'($urandom);
        PRDATA[i*32 +: 32] = $urandom;
      end
    end
  end

  // Monitor: bus-phase checks against the in-flight request, response pop on rsp_valid.
  always @(negedge PCLK) begin
    if (!PRESETn) begin
      prev_sel = 1'b0;
    end else begin
      if (PSEL != '0) begin
        if (exp_q.size() == 0) begin
          chk("psel_unexpected", 32'(PSEL), 32'd0);
        end else begin
          mh = exp_q[0];
          chk("psel", 32'(PSEL), 32'd1 << mh.idx);
          chk("penable", 32'(PENABLE), 32'(prev_sel));
          chk("paddr", PADDR, mh.addr);
          chk("pwrite", 32'(PWRITE), 32'(mh.w));
          chk("pstrb", 32'(PSTRB), mh.w ? 32'(mh.strb) : 32'd0);
          if (mh.w) chk("pwdata", PWDATA, mh.wdata);
        end
      end
      prev_sel = (PSEL != '0);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          mh = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, mh.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(mh.err));
          chk("rsp_cycle", 32'(cyc), 32'(mh.due));
        end
      end else begin
        chk("idle_rdata", rsp_rdata, 32'd0);
        chk("idle_err", 32'(rsp_err), 32'd0);
      end
    end
  end

  // Issue one request at a negedge once req_ready is seen; reference outcome computed from the rules.
  task automatic issue(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int wt, input logic [31:0] rd,
                       input logic er, input bit hold);
    int   guard;
    exp_t e;
    guard = 0;
    while (!req_ready && guard < 400) begin
      @(negedge PCLK);
      guard++;
    end
    if (!req_ready) chk("req_ready_wait", 32'(req_ready), 32'd1);
    e.w     = w;
    e.addr  = addr;
    e.wdata = wdata;
    e.strb  = strb;
    e.idx   = int'(addr[SEL_LSB +: 2]);
    if (e.idx < NSLV) begin
      wait_cfg[e.idx] = wt;
      rd_cfg[e.idx]   = rd;
      er_cfg[e.idx]   = er;
    end
    if (e.idx >= NSLV) begin
      e.rdata = 32'd0;
      e.err   = 1'b1;
      e.due   = cyc + 1;
    end
`ifdef APB_TIMEOUT_EN
    else if (wt >= TMO) begin
      e.rdata = 32'd0;
      e.err   = 1'b1;
      e.due   = cyc + 2 + TMO;
    end
`endif
    else begin
      e.rdata = w ? 32'd0 : rd;
      e.err   = er;
      e.due   = cyc + 3 + wt;
    end
    req_valid = 1'b1;
    req_write = w;
    req_addr  = addr;
    req_wdata = wdata;
    req_strb  = strb;
    exp_q.push_back(e);
    @(negedge PCLK);
    req_valid = hold;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_strb  = 4'($urandom);
  endtask

  task automatic pulse_reset();
    chk("pre_rst_access", 32'(PENABLE), 32'd1);
    PRESETn = 1'b0;
    #1;
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    exp_q.delete();
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    repeat (4) begin
      @(negedge PCLK);
      chk("post_rst_rsp", 32'(rsp_valid), 32'd0);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(negedge PCLK);
      guard++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int          idx;
    logic [31:0] a;
    repeat (3) @(negedge PCLK);
    chk("reset_psel", 32'(PSEL), 32'd0);
    chk("reset_penable", 32'(PENABLE), 32'd0);
    chk("reset_paddr", PADDR, 32'd0);
    chk("reset_pstrb", 32'(PSTRB), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("release_req_ready", 32'(req_ready), 32'd1);

    issue(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 32'h2000_0000, 32'h5555_AAAA, 4'hF, 4, 32'h1234_5678, 1'b0, 1'b0);
    issue(1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 32'h0000_0040, 32'h0, 4'h0, 1, 32'hCAFE_0000, 1'b1, 1'b0);
    issue(1'b1, 32'h0000_0100, 32'h0000_0001, 4'h3, 0, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 32'h1000_0200, 32'h0, 4'h0, 0, 32'h8765_4321, 1'b0, 1'b1);
    issue(1'b1, 32'h2000_0300, 32'h0000_0003, 4'hC, 0, 32'h0, 1'b0, 1'b0);
    drain();

    for (int n = 0; n < 80; n++) begin
      idx = $urandom_range(0, 3);
      a   = {2'($urandom), 2'(idx), 28'($urandom)};
      issue(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3),
            $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
      if (!req_valid) repeat ($urandom_range(0, 2)) @(negedge PCLK);
    end
    req_valid = 1'b0;
    drain();

    issue(1'b0, 32'h1000_0000, 32'h0, 4'h0, 100000, 32'h0, 1'b0, 1'b0);
`ifdef APB_TIMEOUT_EN
    drain();
    issue(1'b0, 32'h2000_0040, 32'h0, 4'h0, 50, 32'h0, 1'b0, 1'b0);
    repeat (3) @(negedge PCLK);
    pulse_reset();
`else
    repeat (100) @(negedge PCLK);
    chk("stuck_psel", 32'(PSEL), 32'h2);
    chk("stuck_penable", 32'(PENABLE), 32'd1);
    pulse_reset();
`endif

    issue(1'b0, 32'h2000_0008, 32'h0, 4'h0, 2, 32'h0BAD_F00D, 1'b0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
